sdram_tmr_array: RTL and testbench
==================================

# sdram_tmr_array

Parametrised array of independent down-counting SDRAM timing counters, one per channel (bank or command-timing slot). Each channel is loaded with a latency value, counts down once per clock, flags expiry with a level and a one-cycle pulse, and can freeze or auto-reload. It sits beside the SDRAM controller state machine and replaces single-purpose CAS-latency, tRCD and tRP counters with one shared block.

## Interface
- CH, default 4: number of independent channels (1..16).
- W, default 4: counter width in bits (2..8). Loadable range 0..2^W-1.

- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- ld  input  CH  per-channel load strobe; bit i loads channel i.
- ld_val  input  CH*W  load values; channel i uses bits [i*W+W-1 : i*W].
- hold  input  CH  per-channel freeze; counter holds its value while high.
- auto_rld  input  CH  per-channel periodic mode enable.
- tm_end  output  CH  level; bit i high when channel i count == 0.
- tm_pulse  output  CH  registered one-cycle pulse on channel expiry.
- busy  output  1  high when any channel count != 0.

## Operation
- Per channel state: count[W-1:0] and rld[W-1:0] (reload value), plus tm_pulse flop.
- Reset (async): all count = 0, rld = 0, tm_pulse = 0. Outputs during/after reset: tm_end = all ones, tm_pulse = 0, busy = 0.
- Per-channel next-state priority at each rising edge, highest first:
  - ld[i]: count <= ld_val slice, rld <= ld_val slice, tm_pulse <= 0. Overrides hold, decrement and expiry.
  - count == 0: count stays 0 (hold ignored), tm_pulse <= 0.
  - hold[i]: count unchanged, tm_pulse <= 0. Pending expiry is deferred, not lost.
  - count == 1 (expiry event): tm_pulse <= 1; count <= rld if auto_rld[i] else 0.
  - otherwise: count <= count - 1, tm_pulse <= 0.
- Loading 0: count stays/becomes 0, tm_end stays high, no pulse.
- auto_rld sampled only at the expiry edge; clearing it mid-count lets the channel finish to 0 at the next expiry. Setting it while count == 0 does nothing until next ld.
- Periodic mode: channel expires every rld cycles (hold cycles excluded); tm_end never rises; rld = 1 gives tm_pulse high every cycle.
- Channels fully independent; no cross-channel arbitration.
- Arithmetic: unsigned W-bit; decrement never wraps (0 is absorbing in one-shot mode).
- tm_end[i] = (count[i] == 0), combinational from registers. busy = OR of ~tm_end, combinational from registers. No input-to-output combinational paths.

## Timing
- Load at edge E with value N >= 1, no hold: count = N after E; tm_end low from E; count = 0 and tm_end high after edge E+N; tm_pulse high for exactly the cycle following edge E+N.
- tm_pulse and the tm_end rising edge are coincident (same cycle) in one-shot mode.
- Each hold cycle during a count delays expiry by exactly one cycle.
- ld at the same edge as an expiry event: ld wins, no pulse, new count = ld_val.
- Reset asserted mid-count: counts, rld and pulses clear immediately (asynchronously); no pulse generated on reset release.
- First ld honoured at the first rising edge after Reset deasserts.

## Test plan
- Reset then idle: Reset high 3 cycles, release -> tm_end = 4'b1111, tm_pulse = 0, busy = 0 for 10 cycles.
- One-shot: CH=4, W=4, ld[0] with value 3 at edge E -> tm_end[0] low after E, high after E+3; tm_pulse[0] high only cycle after E+3; busy high cycles E..E+2.
- Hold: ld[1]=5 at E, hold[1] high for 2 cycles after E+1 -> expiry after E+7, single pulse.
- Periodic: ld[2]=4 with auto_rld[2]=1 -> tm_pulse[2] every 4th cycle, tm_end[2] never high; drop auto_rld[2] -> one further pulse, then tm_end[2] high and stays.
- Collision: channel 3 at count 1 with ld[3]=2 same edge -> no pulse, count 2, expiry 2 cycles later; ld value 0 -> no pulse, tm_end stays high; ld value 15 -> expiry after 15 cycles.
- Reset mid-operation: all four channels loaded 9, Reset at cycle 4 -> all counts 0, tm_end all ones, no tm_pulse after release; W=8, CH=1 build repeats one-shot with value 200.

Source files
------------

// File: rtl/sdram_tmr_array.sv
// Array of independent SDRAM timing counters: one down-counter per channel with
// level and pulse expiry flags, hold/freeze and optional periodic auto-reload.

module sdram_tmr_ch #(
  parameter int W = 4
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         hold,
  input  logic         auto_rld,
  output logic [W-1:0] count,
  output logic         tm_pulse
);
  logic [W-1:0] rld;

  // A load beats everything; zero is absorbing so hold has no effect there.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count    <= '0;
      rld      <= '0;
      tm_pulse <= 1'b0;
    end else if (ld) begin
      count    <= ld_val;
      rld      <= ld_val;
      tm_pulse <= 1'b0;
    end else if (count == '0 || hold) begin
      tm_pulse <= 1'b0;
    end else if (count == W'(1)) begin
      tm_pulse <= 1'b1;
      count    <= auto_rld ? rld : '0;
    end else begin
      count    <= count - W'(1);
      tm_pulse <= 1'b0;
    end
  end
endmodule

module sdram_tmr_array #(
  parameter int CH = 4,
  parameter int W  = 4
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [CH-1:0]   ld,
  input  logic [CH*W-1:0] ld_val,
  input  logic [CH-1:0]   hold,
  input  logic [CH-1:0]   auto_rld,
  output logic [CH-1:0]   tm_end,
  output logic [CH-1:0]   tm_pulse,
  output logic            busy
);
  logic [CH-1:0][W-1:0] count;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    sdram_tmr_ch #(.W(W)) u_ch (
      .Clk      (Clk),
      .Reset    (Reset),
      .ld       (ld[i]),
      .ld_val   (ld_val[i*W +: W]),
      .hold     (hold[i]),
      .auto_rld (auto_rld[i]),
      .count    (count[i]),
      .tm_pulse (tm_pulse[i])
    );
    assign tm_end[i] = (count[i] == '0);
  end

  assign busy = |(~tm_end);
endmodule

// File: tb/tb_sdram_tmr_array.sv
// Randomized and directed bench for sdram_tmr_array against a cycle-level
// behavioural model of each channel's remaining time and reload period.

module tb_sdram_tmr_array;
  localparam int CH = 4;
  localparam int W  = 4;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic [CH-1:0] ld = '0, hold = '0, auto_rld = '0;
  logic [CH*W-1:0] ld_val = '0;
  logic [CH-1:0] tm_end, tm_pulse;
  logic          busy;

  logic          ld_b = 1'b0, hold_b = 1'b0, auto_b = 1'b0;
  logic [7:0]    ld_val_b = '0;
  logic          end_b, pulse_b, busy_b;

  int n_vec = 0, n_err = 0;

  // model state: remaining cycles, reload period, pulse seen this cycle
  int  rem[CH], per[CH];
  bit  pul[CH];
  int  rem_b, per_b;
  bit  pul_b;

  sdram_tmr_array #(.CH(CH), .W(W)) dut (
    .Clk(Clk), .Reset(Reset), .ld(ld), .ld_val(ld_val), .hold(hold),
    .auto_rld(auto_rld), .tm_end(tm_end), .tm_pulse(tm_pulse), .busy(busy)
  );

  sdram_tmr_array #(.CH(1), .W(8)) dut_b (
    .Clk(Clk), .Reset(Reset), .ld(ld_b), .ld_val(ld_val_b), .hold(hold_b),
    .auto_rld(auto_b), .tm_end(end_b), .tm_pulse(pulse_b), .busy(busy_b)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < CH; i++) begin rem[i] = 0; per[i] = 0; pul[i] = 0; end
    rem_b = 0; per_b = 0; pul_b = 0;
  endfunction

  // One timer: reaching zero from one fires; periodic mode restarts the period.
  function automatic void tick(inout int r, inout int p, inout bit pl,
                               input bit l, input int v, input bit h, input bit a);
    pl = 0;
    if (l) begin r = v; p = v; end
    else if (r > 0 && !h) begin
      r = r - 1;
      if (r == 0) begin pl = 1; if (a) r = p; end
    end
  endfunction

  function automatic void model_edge();
    if (Reset) begin model_reset(); return; end
    for (int i = 0; i < CH; i++)
      tick(rem[i], per[i], pul[i], ld[i], int'(ld_val[i*W +: W]), hold[i], auto_rld[i]);
    tick(rem_b, per_b, pul_b, ld_b, int'(ld_val_b), hold_b, auto_b);
  endfunction

  task automatic compare_all();
    logic [CH-1:0] e_end, e_pul;
    for (int i = 0; i < CH; i++) begin
      e_end[i] = (rem[i] == 0);
      e_pul[i] = pul[i];
    end
    chk("tm_end", tm_end, e_end);
    chk("tm_pulse", tm_pulse, e_pul);
    chk("busy", busy, e_end != '1);
    chk("b_end", end_b, rem_b == 0);
    chk("b_pulse", pulse_b, pul_b);
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic load(input int ch, input int v);
    ld[ch] = 1'b1;
    ld_val[ch*W +: W] = W'(v);
  endtask

  initial begin
    int pcnt;
    bit saw_end;
    model_reset();

    // reset held 3 cycles, then idle
    repeat (3) step();
    chk("rst_end", tm_end, 4'hf);
    Reset = 1'b0;
    repeat (10) step();
    chk("idle_end", tm_end, 4'hf);
    chk("idle_busy", busy, 1'b0);

    // one-shot channel 0, value 3
    load(0, 3); step(); ld = '0;
    chk("os_end_E", tm_end[0], 1'b0);
    step(); step();
    chk("os_end_E2", tm_end[0], 1'b0);
    chk("os_busy_E2", busy, 1'b1);
    step();
    chk("os_end_E3", tm_end[0], 1'b1);
    chk("os_pulse_E3", tm_pulse[0], 1'b1);
    step();
    chk("os_pulse_E4", tm_pulse[0], 1'b0);

    // hold channel 1: value 5, two hold cycles after E+1 -> expiry after E+7
    load(1, 5); step(); ld = '0;
    step();
    hold[1] = 1'b1; step(); step(); hold[1] = 1'b0;
    step(); step(); step();
    chk("hold_E6_pulse", tm_pulse[1], 1'b0);
    chk("hold_E6_end", tm_end[1], 1'b0);
    step();
    chk("hold_E7_pulse", tm_pulse[1], 1'b1);

    // periodic channel 2, value 4
    auto_rld[2] = 1'b1; load(2, 4); step(); ld = '0;
    pcnt = 0; saw_end = 0;
    repeat (12) begin step(); pcnt += tm_pulse[2]; saw_end |= tm_end[2]; end
    chk("per_pulses", pcnt, 3);
    chk("per_end_never", saw_end, 1'b0);
    auto_rld[2] = 1'b0;
    pcnt = 0;
    repeat (8) begin step(); pcnt += tm_pulse[2]; end
    chk("per_last_pulse", pcnt, 1);
    chk("per_final_end", tm_end[2], 1'b1);

    // collision on channel 3: reload at count 1 suppresses the pulse
    load(3, 1); step();
    load(3, 2); step(); ld = '0;
    chk("col_pulse", tm_pulse[3], 1'b0);
    chk("col_end", tm_end[3], 1'b0);
    step(); step();
    chk("col_exp", tm_pulse[3], 1'b1);
    load(3, 0); step(); ld = '0;
    chk("ld0_pulse", tm_pulse[3], 1'b0);
    chk("ld0_end", tm_end[3], 1'b1);
    load(3, 15); step(); ld = '0;
    repeat (14) step();
    chk("ld15_pre", tm_end[3], 1'b0);
    step();
    chk("ld15_pulse", tm_pulse[3], 1'b1);

    // asynchronous reset mid-count
    for (int i = 0; i < CH; i++) load(i, 9);
    step(); ld = '0;
    repeat (3) step();
    Reset = 1'b1; model_reset();
    #1;
    chk("arst_end", tm_end, 4'hf);
    chk("arst_pulse", tm_pulse, 4'h0);
    chk("arst_busy", busy, 1'b0);
    step();
    Reset = 1'b0;
    pcnt = 0;
    repeat (12) begin step(); pcnt += $countones(tm_pulse); end
    chk("arst_nopulse", pcnt, 0);

    // wide single-channel build, one-shot 200
    ld_b = 1'b1; ld_val_b = 8'd200; step(); ld_b = 1'b0;
    repeat (199) step();
    chk("b_pre", end_b, 1'b0);
    step();
    chk("b_exp", pulse_b, 1'b1);

    // randomized traffic on all channels
    repeat (400) begin
      for (int i = 0; i < CH; i++) begin
        ld[i] = ($urandom_range(7) == 0);
        ld_val[i*W +: W] = W'($urandom_range(15));
        hold[i] = ($urandom_range(3) == 0);
        auto_rld[i] = $urandom_range(1);
      end
      ld_b = ($urandom_range(15) == 0);
      ld_val_b = 8'($urandom_range(20));
      hold_b = ($urandom_range(3) == 0);
      auto_b = $urandom_range(1);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
